spi_byte_sequencer: RTL
=======================

Name: spi_byte_sequencer

Overview:
Upstream stage of the byte-wide SPI master. Accepts a multi-byte word (e.g. a multiplier product) over a valid/ready handshake and splits it into consecutive 8-bit SPI frames, MSB byte first. For each frame it issues one start pulse to the master and waits for completion. When receive is enabled, it reassembles the returned bytes into a full word. Sits between the multiplier/UART command path and spi_master_slave.

Parameters:
NUM_BYTES, 2, bytes per word (1..4); word width W = 8*NUM_BYTES
GAP_CYCLES, 64, idle clocks after each frame completion before next start (must exceed master inter-frame wait, max 50)
TIMEOUT_CYCLES, 1023, max clocks waiting for frame completion (used only with SPI_SEQ_TIMEOUT_EN)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
word_valid  in  1  upstream word available
word_ready  out  1  sequencer can accept a word
word_data  in  W  word to transmit, MSB byte sent first
word_rx_en  in  1  sampled with word; 1 = also capture MISO bytes
spi_tx_start  out  1  one-cycle start pulse to master (transmit)
spi_rx_start  out  1  one-cycle start pulse to master (receive); equals spi_tx_start & captured rx_en
spi_tx_data  out  8  byte presented to master, stable from start pulse until completion
spi_tx_done  in  1  master transmit-complete level (rises at frame end)
spi_rx_valid  in  1  master receive-valid level (rises at frame end)
spi_rx_data  in  8  master received byte, valid when spi_rx_valid rises
rx_word  out  W  assembled received word
rx_word_valid  out  1  one-cycle pulse, rx_word complete
busy  out  1  high in any state other than IDLE
timeout_err  out  1  one-cycle pulse on frame timeout

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous and active-high. All flops are cleared on reset.
- Reset values: word_ready=1, spi_tx_start=0, spi_rx_start=0, spi_tx_data=0, rx_word=0, rx_word_valid=0, busy=0, timeout_err=0. State is IDLE.
- Completion event: the rising edge of (spi_tx_done | spi_rx_valid), detected against a registered previous value. The previous value resets to 0.
  - The master holds done high until its next transfer, so level is never used — edge only.
- States and transitions:
  - IDLE: word_ready=1. On word_valid&word_ready, latch word_data into shift register, latch word_rx_en, set byte_cnt=0, clear rx accumulator → ISSUE.
  - ISSUE: spi_tx_data = shift register [W-1:W-8]. Pulse spi_tx_start (and spi_rx_start if rx_en) for exactly one cycle → WAIT_DONE.
  - WAIT_DONE: on completion edge:
    - if rx_en, rx_acc <= {rx_acc[W-9:0], spi_rx_data}
    - shift register <<= 8; byte_cnt++
    - → GAP
  - GAP: count GAP_CYCLES. Then:
    - if byte_cnt==NUM_BYTES → DONE
    - else → ISSUE
  - DONE: if rx_en, rx_word <= rx_acc and pulse rx_word_valid. → IDLE.
- Latency: word accept→first start pulse = 1 cycle. Last edge→rx_word_valid = GAP_CYCLES+1 cycles.
- Throughput: the next word can be accepted the cycle after DONE.
- Boundaries:
  - word_valid while busy: ignored (word_ready=0).
  - Completion edge arriving in ISSUE or GAP: ignored, not counted.
  - Reset mid-frame: returns to IDLE on the next clk edge with no start pulse. A stale master done level does not create a false edge, because the previous-value register resets to 0 and the edge is only evaluated in WAIT_DONE.
  - NUM_BYTES=1: a single frame, no intermediate GAP before DONE beyond the one GAP.
  - rx_en=0: rx_word is held unchanged and rx_word_valid never pulses.

Optional Feature:
SPI_SEQ_TIMEOUT_EN
- Defined: a 10-bit counter runs in WAIT_DONE. If it reaches TIMEOUT_CYCLES with no completion edge:
  - pulse timeout_err for one cycle
  - drop the remaining bytes and skip rx_word_valid
  - → IDLE
- Undefined: WAIT_DONE waits indefinitely and timeout_err is tied 0.

Decomposition:
- Package spi_seq_pkg:
  - state enum seq_state_t {IDLE, ISSUE, WAIT_DONE, GAP, DONE}
  - SPI_BYTE_W=8
  - GAP_CNT_W / TIMEOUT_CNT_W width constants
- One sub-module, spi_done_edge_detect: registers the OR of done/valid and outputs a one-cycle rise pulse, with synchronous reset.

Test Plan:
1. NUM_BYTES=2, word_data=16'hA55A, rx_en=0, master model raises done 20 cycles after start → spi_tx_data 8'hA5 then 8'h5A; exactly 2 start pulses ≥64 cycles apart; no rx_word_valid.
2. rx_en=1, model returns 8'h12 then 8'h34 → rx_word=16'h1234 with a single rx_word_valid pulse GAP_CYCLES+1 after the second edge.
3. Hold word_valid high with a second word 16'hFFFF during the first transfer → word_ready=0 until DONE+1; second word sent only after the first completes.
4. Model holds done high from the previous frame at the first ISSUE → no early byte count; sequencer waits for a fresh rise.
5. Assert reset for 1 cycle mid WAIT_DONE → all outputs return to reset values on the next cycle; a new word is then accepted normally.
6. With SPI_SEQ_TIMEOUT_EN, the model never raises done → timeout_err pulses once, 1023 cycles after the start pulse; state returns to IDLE with word_ready=1.

Source files
------------

// File: rtl/spi_seq_pkg.sv
// Shared types and width constants for the SPI byte sequencer.
package spi_seq_pkg;

    localparam int unsigned SPI_BYTE_W    = 8;
    localparam int unsigned GAP_CNT_W     = 8;
    localparam int unsigned TIMEOUT_CNT_W = 10;
    localparam int unsigned BYTE_CNT_W    = 3;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        GAP,
        DONE
    } seq_state_t;

endpackage

// File: rtl/spi_done_edge_detect.sv
// Rising-edge detector on the OR of the master's done/valid levels.
module spi_done_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic done_i,
    input  logic valid_i,
    output logic rise_c_o
);

    logic level_d;
    logic prev_q;

    assign level_d = done_i | valid_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level_d;
        end
    end

    assign rise_c_o = level_d & ~prev_q;

endmodule

// File: rtl/spi_byte_sequencer.sv
// Splits a word into MSB-first SPI byte frames and optionally reassembles the MISO bytes.
// Optional frame-completion timeout is enabled by defining SPI_SEQ_TIMEOUT_EN.
module spi_byte_sequencer
    import spi_seq_pkg::*;
#(
    parameter int unsigned NUM_BYTES  = 2,
    parameter int unsigned GAP_CYCLES = 64
`ifdef SPI_SEQ_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 1023
`endif
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              word_valid,
    output logic                              word_ready,
    input  logic [SPI_BYTE_W*NUM_BYTES-1:0]   word_data,
    input  logic                              word_rx_en,
    output logic                              spi_tx_start,
    output logic                              spi_rx_start,
    output logic [SPI_BYTE_W-1:0]             spi_tx_data,
    input  logic                              spi_tx_done,
    input  logic                              spi_rx_valid,
    input  logic [SPI_BYTE_W-1:0]             spi_rx_data,
    output logic [SPI_BYTE_W*NUM_BYTES-1:0]   rx_word,
    output logic                              rx_word_valid,
    output logic                              busy,
    output logic                              timeout_err
);

    localparam int unsigned W = SPI_BYTE_W * NUM_BYTES;

    seq_state_t                state_q, state_d;
    logic [W-1:0]              shift_q, shift_d;
    logic [W-1:0]              rx_acc_q, rx_acc_d;
    logic                      rx_en_q, rx_en_d;
    logic [BYTE_CNT_W-1:0]     byte_cnt_q, byte_cnt_d;
    logic [GAP_CNT_W-1:0]      gap_cnt_q, gap_cnt_d;

    logic                      word_ready_q, word_ready_d;
    logic                      busy_q, busy_d;
    logic                      tx_start_q, tx_start_d;
    logic                      rx_start_q, rx_start_d;
    logic [SPI_BYTE_W-1:0]     tx_data_q, tx_data_d;
    logic [W-1:0]              rx_word_q, rx_word_d;
    logic                      rx_word_valid_q, rx_word_valid_d;

`ifdef SPI_SEQ_TIMEOUT_EN
    logic [TIMEOUT_CNT_W-1:0]  to_cnt_q, to_cnt_d;
    logic                      timeout_err_q, timeout_err_d;
`endif

    logic                      done_rise_c;

    spi_done_edge_detect u_done_edge (
        .clk      (clk),
        .reset    (reset),
        .done_i   (spi_tx_done),
        .valid_i  (spi_rx_valid),
        .rise_c_o (done_rise_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            shift_q         <= '0;
            rx_acc_q        <= '0;
            rx_en_q         <= 1'b0;
            byte_cnt_q      <= '0;
            gap_cnt_q       <= '0;
            word_ready_q    <= 1'b1;
            busy_q          <= 1'b0;
            tx_start_q      <= 1'b0;
            rx_start_q      <= 1'b0;
            tx_data_q       <= '0;
            rx_word_q       <= '0;
            rx_word_valid_q <= 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
            to_cnt_q        <= '0;
            timeout_err_q   <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            shift_q         <= shift_d;
            rx_acc_q        <= rx_acc_d;
            rx_en_q         <= rx_en_d;
            byte_cnt_q      <= byte_cnt_d;
            gap_cnt_q       <= gap_cnt_d;
            word_ready_q    <= word_ready_d;
            busy_q          <= busy_d;
            tx_start_q      <= tx_start_d;
            rx_start_q      <= rx_start_d;
            tx_data_q       <= tx_data_d;
            rx_word_q       <= rx_word_d;
            rx_word_valid_q <= rx_word_valid_d;
`ifdef SPI_SEQ_TIMEOUT_EN
            to_cnt_q        <= to_cnt_d;
            timeout_err_q   <= timeout_err_d;
`endif
        end
    end

    // Next-state logic; outputs are derived from the next state so they register in step with it.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        rx_acc_d   = rx_acc_q;
        rx_en_d    = rx_en_q;
        byte_cnt_d = byte_cnt_q;
        gap_cnt_d  = gap_cnt_q;
`ifdef SPI_SEQ_TIMEOUT_EN
        to_cnt_d      = to_cnt_q;
        timeout_err_d = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (word_valid && word_ready_q) begin
                    shift_d    = word_data;
                    rx_en_d    = word_rx_en;
                    byte_cnt_d = '0;
                    rx_acc_d   = '0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
`ifdef SPI_SEQ_TIMEOUT_EN
                // Counts clocks since the start pulse.
                to_cnt_d = TIMEOUT_CNT_W'(1);
`endif
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (done_rise_c) begin
                    if (rx_en_q) begin
                        rx_acc_d = W'({rx_acc_q, spi_rx_data});
                    end
                    shift_d    = shift_q << SPI_BYTE_W;
                    byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
                    gap_cnt_d  = '0;
                    state_d    = GAP;
                end
`ifdef SPI_SEQ_TIMEOUT_EN
                else if (to_cnt_q == TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TIMEOUT_CNT_W'(1);
                end
`endif
            end
            GAP: begin
                if (gap_cnt_q == GAP_CNT_W'(GAP_CYCLES - 1)) begin
                    state_d = (byte_cnt_q == BYTE_CNT_W'(NUM_BYTES)) ? DONE : ISSUE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        word_ready_d    = (state_d == IDLE);
        busy_d          = (state_d != IDLE);
        tx_start_d      = (state_d == ISSUE);
        rx_start_d      = (state_d == ISSUE) && rx_en_d;
        tx_data_d       = (state_d == ISSUE) ? shift_d[W-1 -: SPI_BYTE_W] : tx_data_q;
        rx_word_valid_d = (state_d == DONE) && rx_en_d;
        rx_word_d       = rx_word_valid_d ? rx_acc_d : rx_word_q;
    end

    assign word_ready    = word_ready_q;
    assign busy          = busy_q;
    assign spi_tx_start  = tx_start_q;
    assign spi_rx_start  = rx_start_q;
    assign spi_tx_data   = tx_data_q;
    assign rx_word       = rx_word_q;
    assign rx_word_valid = rx_word_valid_q;
`ifdef SPI_SEQ_TIMEOUT_EN
    assign timeout_err   = timeout_err_q;
`else
    assign timeout_err   = 1'b0;
`endif

endmodule
